// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage of the pipeline.
//
// Owns the fetch PC, runs the instruction-memory req/gnt/rvalid protocol with
// at most one request outstanding, and buffers returned words together with
// their PCs in a small prefetch FIFO. The head entry is presented to the IF/ID
// register. Decode pops the head entry by not stalling. A redirect flushes the
// FIFO and restarts fetch at the new target.
//
// Optional feature macro: IF_MISALIGN_EXC_EN
//   defined   : a redirect to a target with [1:0] != 0 raises fetch_misaligned_o
//               (sticky) and blocks new requests until an aligned redirect.
//   undefined : fetch_misaligned_o is tied low and the target low bits are dropped.
//
// Memory handshake:
//   instr_req_o / instr_addr_o are offered until instr_gnt_i is seen high in the
//   same cycle. The address never changes while the request waits for a grant.
//   The granted request is answered by exactly one instr_rvalid_i pulse. Only
//   one request is in flight at a time. A request is issued only when the FIFO
//   is certain to have room for its response.
//
// fsm_state_o exposes the bus FSM state (0 idle, 1 wait grant, 2 wait rvalid).

module instr_fetch_unit #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 2,
  parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_ctrl,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  output logic                  fetch_valid_o,
  output logic [WORD_WIDTH-1:0] program_count_o,
  output logic [WORD_WIDTH-1:0] pc_plus4_o,
  output logic [WORD_WIDTH-1:0] instruction_o,
  output logic                  fetch_misaligned_o,
  output logic [1:0]            fsm_state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = WORD_WIDTH'(32'h0000_0013);
  localparam logic [WORD_WIDTH-1:0] PC_STEP   = WORD_WIDTH'(4);
  localparam logic [CNT_W:0]        OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   fetch_pc_q;
  logic [WORD_WIDTH-1:0]   req_addr_q;
  logic                    discard_q;

  logic [WORD_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]   fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]        count_q;

  logic                    fifo_empty;
  logic                    pop;
  logic                    push;
  logic                    rvalid_in_wait;
  logic                    can_issue_state;
  logic [CNT_W:0]          occ_after;
  logic                    has_space;
  logic                    issue_block;
  logic                    issue;
  logic                    gnt_acc;
  logic                    pending_after;
  logic [WORD_WIDTH-1:0]   target_aligned;

  // ---------------------------------------------------------------------------
  // Misalignment handling (optional)
  // ---------------------------------------------------------------------------
`ifdef IF_MISALIGN_EXC_EN
  logic misaligned_q;

  // Sticky flag: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (branch_i) begin
      misaligned_q <= |branch_target_i[1:0];
    end
  end

  assign fetch_misaligned_o = misaligned_q;
  assign issue_block        = misaligned_q;
`else
  logic unused_target_bits;
  assign unused_target_bits = ^branch_target_i[1:0];
  assign fetch_misaligned_o = 1'b0;
  assign issue_block        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Issue / FIFO control
  // ---------------------------------------------------------------------------
  assign target_aligned = {branch_target_i[WORD_WIDTH-1:2], 2'b00};
  assign fifo_empty     = (count_q == '0);
  assign rvalid_in_wait = (state_q == S_WAIT_RVALID) && instr_rvalid_i;

  // A redirect beats both push and pop: the FIFO is being cleared anyway.
  assign pop  = !fifo_empty && !stall_ctrl && !branch_i;
  assign push = rvalid_in_wait && !discard_q && !branch_i;

  // A new request may start from IDLE, or back-to-back in the cycle the
  // previous response lands.
  assign can_issue_state = (state_q == S_IDLE) || rvalid_in_wait;

  // FIFO occupancy at the end of this cycle counting the landing response
  // and this cycle's pop; a new request must still fit on top of that.
  assign occ_after = {1'b0, count_q}
                   + {{CNT_W{1'b0}}, (state_q == S_WAIT_RVALID)}
                   - {{CNT_W{1'b0}}, pop};
  assign has_space = (occ_after < OCC_LIMIT);

  // No issue while in reset, on a redirect, while a stale response is still
  // owed, or while blocked by a misaligned target.
  assign issue = rst_n && can_issue_state && has_space && !branch_i &&
                 !discard_q && !issue_block;

  assign gnt_acc = instr_req_o && instr_gnt_i;

  // A request is still on the bus after this cycle if it waits for a grant or
  // is granted but its response has not arrived yet.
  assign pending_after = (state_q == S_WAIT_GNT) ||
                         ((state_q == S_WAIT_RVALID) && !instr_rvalid_i);

  // ---------------------------------------------------------------------------
  // Bus FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a grant in the issue cycle skips the wait-grant state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
        end
      end
      S_WAIT_GNT: begin
        if (instr_gnt_i) begin
          state_d = S_WAIT_RVALID;
        end
      end
      S_WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          if (issue) begin
            state_d = instr_gnt_i ? S_WAIT_RVALID : S_WAIT_GNT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs: held request in WAIT_GNT, fresh request from fetch_pc otherwise.
  always_comb begin
    instr_req_o  = (state_q == S_WAIT_GNT) || issue;
    instr_addr_o = (state_q == S_WAIT_GNT) ? req_addr_q : fetch_pc_q;
    fsm_state_o  = state_q;
  end

  // ---------------------------------------------------------------------------
  // PC, request address and discard tracking
  // ---------------------------------------------------------------------------

  // Fetch PC: redirect wins; otherwise step on a grant that is not stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= {BOOT_ADDR[WORD_WIDTH-1:2], 2'b00};
    end else if (branch_i) begin
      fetch_pc_q <= target_aligned;
    end else if (gnt_acc && !discard_q) begin
      fetch_pc_q <= fetch_pc_q + PC_STEP;
    end
  end

  // Address of the in-flight request; also the PC stored with its response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q <= {BOOT_ADDR[WORD_WIDTH-1:2], 2'b00};
    end else if (issue) begin
      req_addr_q <= fetch_pc_q;
    end
  end

  // Discard flag: the in-flight request predates a redirect, drop its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_q <= 1'b0;
    end else if (branch_i && pending_after) begin
      discard_q <= 1'b1;
    end else if (rvalid_in_wait) begin
      discard_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------

  // Pointers and occupancy; a redirect empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (branch_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Entry storage: returned word with the PC it was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr_q]    <= req_addr_q;
      fifo_instr[wr_ptr_q] <= instr_rdata_i;
    end
  end

  // Head-entry view for decode; NOP and the current fetch PC when empty.
  always_comb begin
    fetch_valid_o   = !fifo_empty;
    program_count_o = fifo_empty ? fetch_pc_q : fifo_pc[rd_ptr_q];
    instruction_o   = fifo_empty ? NOP_INSTR : fifo_instr[rd_ptr_q];
    pc_plus4_o      = program_count_o + PC_STEP;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: main instance (BOOT_ADDR 0x80) driven by a
// configurable memory responder, plus a second instance booting at
// 0xFFFF_FFF8 to cover address wrap.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic        stall_ctrl, branch_i;
  logic [31:0] branch_target_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        fetch_valid_o, fetch_misaligned_o;
  logic [31:0] program_count_o, pc_plus4_o, instruction_o;
  logic [1:0]  fsm_state_o;

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .stall_ctrl(stall_ctrl), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .program_count_o(program_count_o),
    .pc_plus4_o(pc_plus4_o), .instruction_o(instruction_o),
    .fetch_misaligned_o(fetch_misaligned_o), .fsm_state_o(fsm_state_o)
  );

  // ---------------- wrap DUT ----------------
  logic        w_stall, w_branch;
  logic [31:0] w_target;
  logic        w_req, w_gnt, w_rvalid, w_valid, w_mis;
  logic [31:0] w_addr, w_rdata, w_pc, w_plus4, w_instr;
  logic [1:0]  w_state;

  instr_fetch_unit #(.BOOT_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_ctrl(w_stall), .branch_i(w_branch),
    .branch_target_i(w_target), .instr_req_o(w_req), .instr_addr_o(w_addr),
    .instr_gnt_i(w_gnt), .instr_rvalid_i(w_rvalid), .instr_rdata_i(w_rdata),
    .fetch_valid_o(w_valid), .program_count_o(w_pc), .pc_plus4_o(w_plus4),
    .instruction_o(w_instr), .fetch_misaligned_o(w_mis), .fsm_state_o(w_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- main memory responder ----------------
  int          gnt_wait = 0;
  int          rv_lat   = 1;
  int          wait_cnt = 0;
  int          last_wait = 0;
  int          gnt_count = 0;
  logic [31:0] last_gnt_addr = '0;
  logic        rv_pending = 1'b0;
  logic [31:0] rv_addr = '0;
  int          rv_cnt = 0;

  initial begin
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        rv_pending = 1'b0; wait_cnt = 0;
        instr_rvalid_i = 1'b0; instr_gnt_i = 1'b0;
      end else begin
        if (rv_pending && rv_cnt == 0) begin
          instr_rvalid_i = 1'b1; instr_rdata_i = mem_word(rv_addr); rv_pending = 1'b0;
        end else begin
          instr_rvalid_i = 1'b0; instr_rdata_i = '0;
          if (rv_pending) rv_cnt--;
        end
        #1;
        if (instr_req_o) begin
          if (wait_cnt >= gnt_wait) begin
            instr_gnt_i = 1'b1; last_wait = wait_cnt; wait_cnt = 0;
            rv_pending = 1'b1; rv_addr = instr_addr_o; rv_cnt = rv_lat - 1;
            gnt_count++; last_gnt_addr = instr_addr_o;
          end else begin
            instr_gnt_i = 1'b0; wait_cnt++;
          end
        end else begin
          instr_gnt_i = 1'b0; wait_cnt = 0;
        end
      end
    end
  end

  // ---------------- behavioural model + compare process (main DUT) ----------------
  // Decode must see consecutive words starting at the boot address or the
  // latest redirect target; the bus must grant consecutive addresses from the
  // same origin, except one stale request that was waiting at redirect time.
  logic [31:0] exp_pc    = 32'h80;
  logic [31:0] exp_fetch = 32'h80;
  logic        exp_mis   = 1'b0;
  logic        stale_valid = 1'b0;
  logic [31:0] stale_addr  = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] prev_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (prev_req && !prev_gnt) begin
          chk("req_hold", instr_req_o, 1);
          chk("addr_hold", instr_addr_o, prev_addr);
        end
        if (instr_req_o) chk("addr_align", instr_addr_o[1:0], 0);
        if (instr_req_o && instr_gnt_i) begin
          if (stale_valid) begin
            chk("stale_addr", instr_addr_o, stale_addr);
            stale_valid = 1'b0;
          end else begin
            chk("fetch_addr", instr_addr_o, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
          end
        end
        if (fetch_valid_o) begin
          chk("head_pc", program_count_o, exp_pc);
          chk("head_pc4", pc_plus4_o, exp_pc + 32'd4);
          chk("head_instr", instruction_o, mem_word(exp_pc));
        end else begin
          chk("empty_nop", instruction_o, NOP);
        end
        chk("misaligned_flag", fetch_misaligned_o, exp_mis);
        if (branch_i) begin
          if (instr_req_o && !instr_gnt_i) begin
            stale_valid = 1'b1; stale_addr = exp_fetch;
          end
          exp_pc    = {branch_target_i[31:2], 2'b00};
          exp_fetch = {branch_target_i[31:2], 2'b00};
`ifdef IF_MISALIGN_EXC_EN
          exp_mis   = |branch_target_i[1:0];
`endif
        end else if (fetch_valid_o && !stall_ctrl) begin
          exp_pc = exp_pc + 32'd4;
        end
        prev_req = instr_req_o; prev_gnt = instr_gnt_i; prev_addr = instr_addr_o;
      end
    end
  end

  // ---------------- wrap instance: always-grant responder and checker ----------------
  logic        w_pend = 1'b0;
  logic [31:0] w_pend_addr = '0;
  logic [31:0] w_exp = 32'hFFFF_FFF8;
  logic [31:0] w_exp_addr = 32'hFFFF_FFF8;
  int          w_pops = 0;
  int          w_grants = 0;

  initial begin
    w_stall = 1'b0; w_branch = 1'b0; w_target = '0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      w_rvalid = w_pend && rst_n;
      w_rdata  = mem_word(w_pend_addr);
      #1;
      w_gnt = w_req;
      w_pend = w_req;
      if (w_req) w_pend_addr = w_addr;
      #1;
      if (rst_n) begin
        if (w_req && w_gnt && w_grants < 3) begin
          chk("wrap_addr", w_addr, w_exp_addr);
          w_exp_addr = w_exp_addr + 32'd4;
          w_grants++;
        end
        if (w_valid && w_pops < 4) begin
          chk("wrap_pc", w_pc, w_exp);
          chk("wrap_pc4", w_plus4, w_exp + 32'd4);
          chk("wrap_instr", w_instr, mem_word(w_exp));
          if (w_pc == 32'hFFFF_FFFC) chk("wrap_pc4_zero", w_plus4, 32'h0);
          w_exp = w_exp + 32'd4;
          w_pops++;
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  logic [31:0] held_pc, old_fetch;
  int          gc0;
  logic        found;

  task automatic wait_valid(input string name, input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(); #4;
      if (fetch_valid_o) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  task automatic wait_grant_after(input string name, input int base, input int budget);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick(); #4;
      if (gnt_count > base) found = 1'b1;
    end
    chk(name, found, 1);
  endtask

  initial begin
    rst_n = 1'b0; stall_ctrl = 1'b0; branch_i = 1'b0; branch_target_i = '0;
    repeat (3) tick();
    #4;
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_req", instr_req_o, 0);
    chk("rst_instr", instruction_o, NOP);
    chk("rst_pc", program_count_o, 32'h80);
    chk("rst_pc4", pc_plus4_o, 32'h84);
    chk("rst_mis", fetch_misaligned_o, 0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap_rst_pc4", w_plus4, 32'hFFFF_FFFC);

    // 1: boot stream, same-cycle grant, one-cycle response
    tick(); rst_n = 1'b1;
    #4 chk("first_req_addr", instr_addr_o, 32'h80);
    wait_valid("first_valid_timeout", 20);
    chk("first_pc", program_count_o, 32'h80);
    chk("first_pc4", pc_plus4_o, 32'h84);
    chk("first_instr", instruction_o, mem_word(32'h80));
    for (int i = 0; i < 6; i++) begin
      tick(); #4;
      chk("no_gap", fetch_valid_o, 1);
    end

    // 2: five-cycle stall fills the FIFO and stops requests
    tick(); stall_ctrl = 1'b1;
    #4 held_pc = exp_pc;
    for (int i = 0; i < 4; i++) begin
      tick(); #4;
      chk("stall_hold", program_count_o, held_pc);
    end
    chk("stall_full_noreq", instr_req_o, 0);
    chk("stall_valid", fetch_valid_o, 1);
    tick(); stall_ctrl = 1'b0;
    #4 chk("resume_req", instr_req_o, 1);
    repeat (6) tick();

    // 3: redirect while the 0x90 response is outstanding
    rv_lat = 3;
    tick(); branch_i = 1'b1; branch_target_i = 32'h90;
    tick(); branch_i = 1'b0;
    #4 chk("branch_clears_valid", fetch_valid_o, 0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #4;
      if (rv_pending && rv_addr == 32'h90) found = 1'b1;
    end
    chk("wait_0x90_timeout", found, 1);
    tick(); branch_i = 1'b1; branch_target_i = 32'h200;
    gc0 = gnt_count;
    tick(); branch_i = 1'b0;
    #4 chk("branch2_clears_valid", fetch_valid_o, 0);
    wait_grant_after("grant_0x200_timeout", gc0, 20);
    chk("next_addr_0x200", last_gnt_addr, 32'h200);
    wait_valid("valid_0x200_timeout", 20);
    chk("first_pc_0x200", program_count_o, 32'h200);
    rv_lat = 1;
    repeat (4) tick();

    // 4: grant withheld three cycles, redirect during the wait
    gnt_wait = 3;
    gc0 = gnt_count;
    wait_grant_after("slow_grant_timeout", gc0, 20);
    chk("gnt_wait_len", last_wait, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #4;
      if (instr_req_o && wait_cnt == 1) found = 1'b1;
    end
    chk("req_wait_timeout", found, 1);
    old_fetch = exp_fetch;
    gc0 = gnt_count;
    tick(); branch_i = 1'b1; branch_target_i = 32'h300;
    tick(); branch_i = 1'b0;
    wait_grant_after("old_grant_timeout", gc0, 20);
    chk("old_addr_granted", last_gnt_addr, old_fetch);
    gnt_wait = 0;
    wait_valid("valid_0x300_timeout", 20);
    chk("first_pc_0x300", program_count_o, 32'h300);
    repeat (4) tick();

    // 6: misaligned redirect target
    tick(); branch_i = 1'b1; branch_target_i = 32'h102;
    tick(); branch_i = 1'b0;
`ifdef IF_MISALIGN_EXC_EN
    #4 chk("mis_set", fetch_misaligned_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); #4;
      chk("mis_noreq", instr_req_o, 0);
      chk("mis_novalid", fetch_valid_o, 0);
    end
    tick(); branch_i = 1'b1; branch_target_i = 32'h100;
    tick(); branch_i = 1'b0;
    #4 chk("mis_clear", fetch_misaligned_o, 0);
`else
    #4 chk("mis_tied_low", fetch_misaligned_o, 0);
`endif
    wait_valid("valid_0x100_timeout", 20);
    chk("first_pc_0x100", program_count_o, 32'h100);
    chk("first_instr_0x100", instruction_o, mem_word(32'h100));
    repeat (4) tick();

    // 5: wrap instance delivered its first four words
    chk("wrap_pops", w_pops, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
